seq_bin_multiplier: RTL
=======================

Name: seq_bin_multiplier

Overview:
Parametrised iterative shift-add multiplier, successor to the combinational array multiplier.
- Retires K multiplier bits per clock.
- Supports unsigned and two's-complement signed operands, selected per operation.
- Uses valid/ready handshakes on both input and output, so it sits directly between a register-file/bus front end and a result consumer that may stall.
- Trades area for latency: one K×D partial-product adder instead of D.

Parameters:
- D, 16: operand width in bits; must be ≥ 2.
- K, 1: multiplier bits retired per cycle. Must divide D evenly. An illegal value halts elaboration via a generate-time check.
- N (localparam), 2*D: product width.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: operands and mode are presented.
- in_ready, output, 1: block can accept an operation.
- signed_mode, input, 1: 1 = two's-complement operands; 0 = unsigned. Sampled with the operands.
- dba, input, D: multiplicand.
- dbb, input, D: multiplier.
- out_valid, output, 1: Y holds a completed product.
- out_ready, input, 1: consumer accepts the result.
- busy, output, 1: operation in progress (RUN state).
- Y, output, N: product register.
- yA, output, D: Y[D-1:0].
- yB, output, D: Y[N-1:D].

Behaviour:
- Reset (rst=1 at an edge), with priority over every other event:
  - State goes to IDLE.
  - Y=0, out_valid=0, busy=0, in_ready=1 after the edge.
  - Iteration counter and working registers are cleared.
  - Reset during RUN or DONE aborts the operation; no result is ever presented for it.
- FSM states: IDLE, RUN, DONE. Outputs per state:
  - IDLE: in_ready=1, busy=0, out_valid=0.
  - RUN: in_ready=0, busy=1, out_valid=0.
  - DONE: in_ready=0, busy=0, out_valid=1.
- IDLE → RUN on the edge where in_valid && in_ready. At that edge:
  - dba, dbb and signed_mode are captured.
  - The captured negate flag is dba[D-1]^dbb[D-1] when signed_mode=1, else 0.
  - Operand magnitudes are captured: when signed_mode=1 and the MSB is set, the D-bit unsigned two's-complement negation; otherwise the raw value. -2^(D-1) maps to 2^(D-1), which fits in D unsigned bits.
  - Accumulator and counter are cleared.
- RUN, each cycle:
  - The accumulator adds Σ over i=0..K-1 of (mag_b[i] ? mag_a<<(i+shift) : 0), where shift = K·count.
  - mag_b shifts right by K; count increments.
  - The accumulator is N bits wide and never overflows.
- RUN → DONE on the edge where count reaches D/K-1. On that same edge Y is loaded with the final accumulator, two's-complement negated in N bits if the negate flag is set.
- DONE → IDLE on the edge where out_valid && out_ready. in_ready returns to 1 on the following cycle; there is no same-cycle reload.
- Latency is fixed and data-independent: out_valid rises exactly D/K edges after the accept edge. D=16, K=1 gives 16 cycles; K=4 gives 4 cycles. Zero operands take the full latency, with no early exit.
- Y is written only on the RUN→DONE edge and on reset. It holds its value through DONE, back-pressure and the following IDLE, until the next completion.
- in_valid is ignored outside IDLE. Operand and mode changes during RUN/DONE do not affect the result.
- Arithmetic:
  - Unsigned: Y = dba*dbb, exact in N bits.
  - Signed: Y = two's-complement N-bit product. Always exact; the largest case, (-2^(D-1))², equals 2^(N-2).

Test Plan:
- Unsigned max, D=16, K=1: in_valid with signed_mode=0, dba=0xFFFF, dbb=0xFFFF, out_ready=1 → out_valid high exactly 16 edges after accept; Y=0xFFFE0001, yB=0xFFFE, yA=0x0001; in_ready=1 one cycle after the handshake.
- Signed corners: (0xFFFF,0xFFFF) → Y=0x00000001; (0x8000,0x8000) → Y=0x40000000; (0x8000,0x0001) → Y=0xFFFF8000; (0x0000,0x8000) → Y=0x00000000.
- Back-pressure: complete 0x1234×0x0010 (unsigned) with out_ready=0 for 5 cycles, toggling in_valid and operands meanwhile → out_valid, Y=0x00012340 and in_ready=0 held stable; the handshake occurs only when out_ready=1; no new operation is started.
- Reset mid-operation: assert rst for one cycle at RUN count 7 → next cycle IDLE, Y=0, out_valid=0, busy=0, in_ready=1. A subsequent 3×5 produces Y=15 after 16 cycles.
- K=4 build (D=16): 0xABCD×0x1234 unsigned → Y=0x0C37_4FA4 after exactly 4 cycles. Back-to-back operations with out_ready tied high give an accept-to-accept spacing of 6 cycles.
- Randomised cross-check (supplementary): 1000 random operand/mode pairs for K∈{1,2,8} against a reference model; every Y matches and latency is constant.

Source files
------------

// File: rtl/seq_bin_multiplier_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_bin_multiplier_if
//  Description : Operand/result handshake bundle for seq_bin_multiplier.
//                The master side presents operands and consumes results.
//                The slave side is the multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_bin_multiplier_if #(
    parameter int D = 16
);
    localparam int N = 2 * D;

    logic         in_valid;
    logic         in_ready;
    logic         signed_mode;
    logic [D-1:0] dba;
    logic [D-1:0] dbb;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic [N-1:0] Y;
    logic [D-1:0] yA;
    logic [D-1:0] yB;

    modport master (
        output in_valid, signed_mode, dba, dbb, out_ready,
        input  in_ready, out_valid, busy, Y, yA, yB
    );

    modport slave (
        input  in_valid, signed_mode, dba, dbb, out_ready,
        output in_ready, out_valid, busy, Y, yA, yB
    );
endinterface
`default_nettype wire

// File: rtl/seq_bin_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : seq_bin_multiplier
//  Description : Iterative shift-add multiplier retiring K multiplier bits
//                per clock. Signed operands are multiplied as magnitudes and
//                the product is negated once at completion. Fixed latency of
//                D/K cycles from accept to out_valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_bin_multiplier #(
    parameter int D = 16,
    parameter int K = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    seq_bin_multiplier_if.slave bus
);

    localparam int N     = 2 * D;
    localparam int STEPS = (K > 0) ? (D / K) : 1;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int SW    = $clog2(N) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Reject operand widths / step sizes that cannot be iterated evenly.
    generate
        if ((D < 2) || (K < 1) || (K > D) || ((D % ((K > 0) ? K : 1)) != 0)) begin : g_param_check_fail
            $error("seq_bin_multiplier: D must be >= 2 and K must evenly divide D");
        end
    endgenerate

    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic [D-1:0]  r_mag_a;
    logic [D-1:0]  r_mag_b;
    logic          r_neg;
    logic [N-1:0]  r_acc;
    logic [CW-1:0] r_count;
    logic [N-1:0]  r_y;

    logic          w_in_ready;
    logic          w_busy;
    logic          w_out_valid;
    logic          w_accept;
    logic          w_last;
    logic [D-1:0]  w_mag_a;
    logic [D-1:0]  w_mag_b;
    logic          w_neg;
    logic [SW-1:0] w_shift;
    logic [N-1:0]  w_a_shifted;
    logic [N-1:0]  w_pp_term [K];
    logic [N-1:0]  w_pp_sum;
    logic [N-1:0]  w_acc_next;

    // Operand capture: magnitudes of signed operands, raw value otherwise.
    // The most negative value negates to itself, which read unsigned is its
    // correct magnitude.
    assign w_accept = bus.in_valid && w_in_ready;
    assign w_mag_a  = (bus.signed_mode && bus.dba[D-1]) ? -bus.dba : bus.dba;
    assign w_mag_b  = (bus.signed_mode && bus.dbb[D-1]) ? -bus.dbb : bus.dbb;
    assign w_neg    = bus.signed_mode && (bus.dba[D-1] ^ bus.dbb[D-1]);

    // Multiplicand aligned to the weight of the current K-bit group.
    assign w_shift     = SW'(r_count) * SW'(K);
    assign w_a_shifted = {{D{1'b0}}, r_mag_a} << w_shift;
    assign w_last      = (r_count == CW'(STEPS - 1));

    // One partial product per multiplier bit retired this cycle.
    generate
        for (genvar gi = 0; gi < K; gi++) begin : g_pp
            assign w_pp_term[gi] = r_mag_b[gi] ? (w_a_shifted << gi) : '0;
        end
    endgenerate

    // Sum the K partial products of this cycle.
    always_comb begin
        w_pp_sum = '0;
        for (int i = 0; i < K; i++) begin
            w_pp_sum = w_pp_sum + w_pp_term[i];
        end
    end

    assign w_acc_next = r_acc + w_pp_sum;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)      w_state_next = S_RUN;
            S_RUN:   if (w_last)        w_state_next = S_DONE;
            S_DONE:  if (bus.out_ready) w_state_next = S_IDLE;
            default:                    w_state_next = S_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state.
    always_comb begin
        w_in_ready  = 1'b0;
        w_busy      = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE:  w_in_ready  = 1'b1;
            S_RUN:   w_busy      = 1'b1;
            S_DONE:  w_out_valid = 1'b1;
            default: w_in_ready  = 1'b0;
        endcase
    end

    // Datapath: capture on accept, accumulate in RUN, load product on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mag_a <= '0;
            r_mag_b <= '0;
            r_neg   <= 1'b0;
            r_acc   <= '0;
            r_count <= '0;
            r_y     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mag_a <= w_mag_a;
                        r_mag_b <= w_mag_b;
                        r_neg   <= w_neg;
                        r_acc   <= '0;
                        r_count <= '0;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_acc_next;
                    r_mag_b <= r_mag_b >> K;
                    if (w_last) begin
                        r_count <= '0;
                        r_y     <= r_neg ? -w_acc_next : w_acc_next;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.busy      = w_busy;
    assign bus.out_valid = w_out_valid;
    assign bus.Y         = r_y;
    assign bus.yA        = r_y[D-1:0];
    assign bus.yB        = r_y[N-1:D];

endmodule
`default_nettype wire
